multicycle_control: RTL and testbench

- Moore-style FSM that sequences the shared multicycle MIPS datapath: one ALU, one unified instruction/data memory port, and the register file.
- Replaces per-instruction combinational decode with per-state control. Each instruction takes 3–5 states plus memory wait cycles.
- Stalls on a memory ready handshake. Traps on illegal opcodes and on memory timeouts.
- Sits between the instruction register (op/funct), the ALU zero flag, the memory interface, and the datapath muxes and enables.

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/multicycle_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control FSM
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_R_WB,
        ST_EXEC_I,
        ST_I_WB,
        ST_MEM_ADDR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // ALU_NONE marks an unsupported R-type function field.
    function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
        case (funct)
            FUNCT_ADD: return ALU_ADD;
            FUNCT_SUB: return ALU_SUB;
            FUNCT_AND: return ALU_AND;
            FUNCT_OR:  return ALU_OR;
            FUNCT_SLT: return ALU_SLT;
            default:   return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags a timeout
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expires on the cycle the count would reach the limit; a ready in that cycle wins.
    always_comb begin
        expired = active && !ready && (cnt_q == LAST_WAIT);
        cnt_d   = cnt_q + 1'b1;
        if (!active || ready || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the shared multicycle MIPS datapath
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] trap_cause_q;
    logic [1:0] trap_cause_d;
    logic       mem_active;
    logic       mem_expired;
    logic [2:0] r_alu;

    assign mem_active = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                        (state_q == ST_MEM_WRITE);
    assign r_alu      = funct_to_alu(funct);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_mem_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .active (mem_active),
        .ready  (mem_ready),
        .expired(mem_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Outputs are held at zero while reset is high, whatever state is still registered.
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RT;
        alu_ctrl     = ALU_NONE;
        pc_src       = PCSRC_ALU;
        trap         = 1'b0;
        trap_cause   = CAUSE_NONE;
        if (!reset) begin
            trap_cause = trap_cause_q;
            case (state_q)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_ctrl  = ALU_ADD;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PCSRC_ALU;
                        state_d  = ST_DECODE;
                    end else if (mem_expired) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    alu_ctrl  = ALU_ADD;
                    case (op)
                        OP_RTYPE:     state_d = ST_EXEC_R;
                        OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                        OP_ADDI:      state_d = ST_EXEC_I;
                        OP_BEQ:       state_d = ST_BRANCH;
                        OP_J:         state_d = ST_JUMP;
                        default: begin
                            state_d      = ST_TRAP;
                            trap_cause_d = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_ctrl  = r_alu;
                    if (r_alu == ALU_NONE) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = ST_R_WB;
                    end
                end
                ST_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = ALU_ADD;
                    state_d   = ST_I_WB;
                end
                ST_I_WB: begin
                    reg_write = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = ALU_ADD;
                    if (op == OP_LW) begin
                        state_d = ST_MEM_READ;
                    end else if (op == OP_SW) begin
                        state_d = ST_MEM_WRITE;
                    end else begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                end
                ST_MEM_READ, ST_MEM_WRITE: begin
                    iord      = 1'b1;
                    mem_read  = (state_q == ST_MEM_READ);
                    mem_write = (state_q == ST_MEM_WRITE);
                    if (mem_ready) begin
                        state_d = (state_q == ST_MEM_READ) ? ST_MEM_WB : ST_FETCH;
                    end else if (mem_expired) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_TIMEOUT;
                    end
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = zero;
                    state_d   = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                    state_d  = ST_FETCH;
                end
                ST_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, trap;
    logic [1:0] alu_src_b, pc_src, trap_cause;
    logic [2:0] alu_ctrl;

    typedef struct packed {
        logic       pc_write, ir_write, iord, mem_read, mem_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       trap;
        logic [1:0] trap_cause;
    } ctl_t;

    ctl_t exp_q[$];
    ctl_t mon_e;
    ctl_t mon_g;
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .trap(trap), .trap_cause(trap_cause)
    );

    function automatic ctl_t got_vec();
        ctl_t g;
        g.pc_write = pc_write;   g.ir_write = ir_write;     g.iord = iord;
        g.mem_read = mem_read;   g.mem_write = mem_write;   g.mem_to_reg = mem_to_reg;
        g.reg_dst = reg_dst;     g.reg_write = reg_write;   g.alu_src_a = alu_src_a;
        g.alu_src_b = alu_src_b; g.alu_ctrl = alu_ctrl;     g.pc_src = pc_src;
        g.trap = trap;           g.trap_cause = trap_cause;
        return g;
    endfunction

    always @(negedge clk) begin
        cyc_n++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = got_vec();
            total++;
            if (mon_g !== mon_e) begin
                bad++;
                $display("FAIL ctl_vec cycle=%0d got=%b exp=%b", cyc_n, mon_g, mon_e);
            end
        end
    end

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic cyc(input logic rdy, input logic rst, input ctl_t e);
        mem_ready = rdy;
        reset     = rst;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic trap_then_reset(input logic [1:0] cause, input int n);
        ctl_t v;
        v = '0;
        v.trap = 1'b1;
        v.trap_cause = cause;
        for (int i = 0; i < n; i++) begin
            op = 6'($urandom);
            funct = 6'($urandom);
            zero = rnd();
            cyc(rnd(), 1'b0, v);
        end
        for (int i = 0; i < 2; i++) cyc(rnd(), 1'b1, '0);
    endtask

    // w = number of not-ready cycles before ready; w >= TMO means the access never completes.
    task automatic mem_access(input ctl_t wait_v, input ctl_t done_v, input int w, output bit ok);
        for (int i = 0; i < w && i < TMO; i++) cyc(1'b0, 1'b0, wait_v);
        if (w >= TMO) begin
            ok = 1'b0;
        end else begin
            cyc(1'b1, 1'b0, done_v);
            ok = 1'b1;
        end
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fw, input int mw, input int trap_n);
        ctl_t       v;
        ctl_t       d;
        bit         ok;
        logic [2:0] alu;
        op = o; funct = f; zero = z;
        v = '0; v.mem_read = 1; v.alu_src_b = 2'd1; v.alu_ctrl = 3'b001;
        d = v;  d.ir_write = 1; d.pc_write = 1;
        mem_access(v, d, fw, ok);
        if (!ok) begin
            trap_then_reset(2'd2, trap_n);
            return;
        end
        v = '0; v.alu_src_b = 2'd3; v.alu_ctrl = 3'b001;
        cyc(rnd(), 1'b0, v);
        case (o)
            6'b000000: begin
                case (f)
                    6'b100000: alu = 3'b001;
                    6'b100010: alu = 3'b010;
                    6'b100100: alu = 3'b011;
                    6'b100101: alu = 3'b100;
                    6'b101010: alu = 3'b101;
                    default:   alu = 3'b000;
                endcase
                v = '0; v.alu_src_a = 1; v.alu_ctrl = alu;
                cyc(rnd(), 1'b0, v);
                if (alu == 3'b000) begin
                    trap_then_reset(2'd1, trap_n);
                end else begin
                    v = '0; v.reg_write = 1; v.reg_dst = 1;
                    cyc(rnd(), 1'b0, v);
                end
            end
            6'b100011, 6'b101011: begin
                v = '0; v.alu_src_a = 1; v.alu_src_b = 2'd2; v.alu_ctrl = 3'b001;
                cyc(rnd(), 1'b0, v);
                v = '0; v.iord = 1;
                if (o == 6'b100011) v.mem_read = 1;
                else v.mem_write = 1;
                mem_access(v, v, mw, ok);
                if (!ok) begin
                    trap_then_reset(2'd2, trap_n);
                end else if (o == 6'b100011) begin
                    v = '0; v.reg_write = 1; v.mem_to_reg = 1;
                    cyc(rnd(), 1'b0, v);
                end
            end
            6'b001000: begin
                v = '0; v.alu_src_a = 1; v.alu_src_b = 2'd2; v.alu_ctrl = 3'b001;
                cyc(rnd(), 1'b0, v);
                v = '0; v.reg_write = 1;
                cyc(rnd(), 1'b0, v);
            end
            6'b000100: begin
                v = '0; v.alu_src_a = 1; v.alu_ctrl = 3'b010; v.pc_src = 2'd1; v.pc_write = z;
                cyc(rnd(), 1'b0, v);
            end
            6'b000010: begin
                v = '0; v.pc_write = 1; v.pc_src = 2'd2;
                cyc(rnd(), 1'b0, v);
            end
            default: trap_then_reset(2'd1, trap_n);
        endcase
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(9, 0);
        if (r < 6) return 0;
        if (r < 9) return $urandom_range(4, 1);
        return $urandom_range(18, 14);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d got=stuck exp=finish", cyc_n);
        $fatal(1);
    end

    initial begin
        logic [5:0] legal_f [5];
        logic [5:0] legal_op [6];
        ctl_t       v;
        int         r;
        legal_f  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        legal_op = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, '0);

        instr(6'b000000, 6'b100000, 1'b0, 0, 0, 3);
        instr(6'b100011, 6'b000000, 1'b0, 0, 3, 3);
        instr(6'b000100, 6'b000000, 1'b1, 0, 0, 3);
        instr(6'b000100, 6'b000000, 1'b0, 0, 0, 3);
        instr(6'b111111, 6'b000000, 1'b0, 0, 0, 20);
        instr(6'b101011, 6'b000000, 1'b0, 0, 16, 3);
        instr(6'b101011, 6'b000000, 1'b0, 0, 15, 3);
        instr(6'b000000, 6'b111000, 1'b1, 0, 0, 3);
        instr(6'b001000, 6'b000000, 1'b0, 2, 0, 3);
        instr(6'b000010, 6'b000000, 1'b1, 16, 0, 3);

        // lw interrupted by reset while waiting on memory
        op = 6'b100011; funct = '0; zero = 1'b0;
        v = '0; v.mem_read = 1; v.alu_src_b = 2'd1; v.alu_ctrl = 3'b001; v.ir_write = 1; v.pc_write = 1;
        cyc(1'b1, 1'b0, v);
        v = '0; v.alu_src_b = 2'd3; v.alu_ctrl = 3'b001;
        cyc(1'b0, 1'b0, v);
        v = '0; v.alu_src_a = 1; v.alu_src_b = 2'd2; v.alu_ctrl = 3'b001;
        cyc(1'b1, 1'b0, v);
        v = '0; v.iord = 1; v.mem_read = 1;
        cyc(1'b0, 1'b0, v);
        cyc(1'b0, 1'b0, v);
        cyc(1'b1, 1'b1, '0);
        instr(6'b000000, 6'b101010, 1'b0, 0, 0, 3);

        for (int n = 0; n < 150; n++) begin
            logic [5:0] o;
            logic [5:0] f;
            r = $urandom_range(9, 0);
            o = (r < 8) ? legal_op[$urandom_range(5, 0)] : 6'($urandom);
            f = (r == 9) ? 6'($urandom) : legal_f[$urandom_range(4, 0)];
            instr(o, f, rnd(), pick_wait(), pick_wait(), $urandom_range(4, 1));
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
